trail_painter: RTL



---
 rtl/trail_pkg.sv | 23 ++
 rtl/trail_fb_ram.sv | 25 ++
 rtl/trail_painter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/trail_pkg.sv
// Shared types and helpers for the trail painter: direction/state enums, button
// bit positions and the single-axis stepping rule used for both x and y.
package trail_pkg;

    typedef enum logic [1:0] {DirRight, DirLeft, DirUp, DirDown} dir_t;
    typedef enum logic [1:0] {StIdle, StMove, StClear} state_t;

    localparam int unsigned BtnRight = 0;
    localparam int unsigned BtnLeft  = 1;
    localparam int unsigned BtnUp    = 2;
    localparam int unsigned BtnDown  = 3;

    // Moves coord by delta within [0, lim-1]; off-edge either holds or wraps.
    function automatic int unsigned step_coord(input int unsigned coord, input int delta,
                                               input int unsigned lim, input bit wrap);
        int nxt;
        nxt = int'(coord) + delta;
        if (nxt < 0) return wrap ? lim - 32'd1 : coord;
        if (nxt >= int'(lim)) return wrap ? 32'd0 : coord;
        return unsigned'(nxt);
    endfunction

endpackage

// File: rtl/trail_fb_ram.sv
// Framebuffer storage: one write port, one registered read port. A read of the
// address being written in the same cycle returns the previous contents.
module trail_fb_ram #(
    parameter int unsigned CW    = 1,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/trail_painter.sv
// Pen-trail painter: button presses move a cursor that writes colour into the
// framebuffer; the raster reads pixels back with one cycle of latency.
module trail_painter
    import trail_pkg::*;
#(
    parameter int unsigned HSIZE = 480,
    parameter int unsigned VSIZE = 272,
    parameter int unsigned CW    = 1,
    parameter int unsigned STEP  = 5,
    parameter int unsigned WRAP  = 0,
    parameter int unsigned X0    = 0,
    parameter int unsigned Y0    = 0,
    localparam int unsigned XW   = $clog2(HSIZE),
    localparam int unsigned YW   = $clog2(VSIZE),
    localparam int unsigned AW   = $clog2(HSIZE * VSIZE)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [3:0]    PushButton,
    input  logic          i_clear,
    input  logic          i_pen_down,
    input  logic [CW-1:0] i_color,
    input  logic [XW:0]   i_hpos,
    input  logic [YW:0]   i_vpos,
    output logic [CW-1:0] o_pixel,
    output logic          o_cursor,
    output logic          o_busy,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y
);

    localparam int unsigned NPIX   = HSIZE * VSIZE;
    localparam bit          WrapEn = (WRAP != 0);

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] caddr_q, caddr_d;
    logic [3:0]    btn_q;
    logic          clr_q;
    logic          in_range_q;
    logic          cursor_q;

    logic [3:0]    press;
    logic          clr_edge;
    logic          we;
    logic [AW-1:0] waddr;
    logic [CW-1:0] wdata;
    logic          rd_in_range;
    logic [AW-1:0] raddr;
    logic          cursor_hit;
    logic [CW-1:0] ram_rdata;

    assign press    = PushButton & ~btn_q;
    assign clr_edge = i_clear & ~clr_q;

    // Out-of-range raster positions read address 0 and are masked on output.
    assign rd_in_range = (32'(i_hpos) < HSIZE) && (32'(i_vpos) < VSIZE);
    assign raddr       = rd_in_range ?
                         (AW'(i_vpos[YW-1:0]) * AW'(HSIZE) + AW'(i_hpos[XW-1:0])) : '0;
    assign cursor_hit  = (i_hpos == {1'b0, x_q}) && (i_vpos == {1'b0, y_q});

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StClear;
            dir_q      <= DirRight;
            cnt_q      <= '0;
            x_q        <= XW'(X0);
            y_q        <= YW'(Y0);
            caddr_q    <= '0;
            btn_q      <= '0;
            clr_q      <= 1'b0;
            in_range_q <= 1'b0;
            cursor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            caddr_q    <= caddr_d;
            btn_q      <= PushButton;
            clr_q      <= i_clear;
            in_range_q <= rd_in_range;
            cursor_q   <= cursor_hit;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        caddr_d = caddr_q;
        unique case (state_q)
            StIdle: begin
                if (clr_edge) begin
                    caddr_d = '0;
                    state_d = StClear;
                end else if (|press) begin
                    cnt_d   = 8'(STEP);
                    state_d = StMove;
                    if (press[BtnRight])     dir_d = DirRight;
                    else if (press[BtnLeft]) dir_d = DirLeft;
                    else if (press[BtnUp])   dir_d = DirUp;
                    else                     dir_d = DirDown;
                end
            end
            StMove: begin
                unique case (dir_q)
                    DirRight: x_d = XW'(step_coord(32'(x_q), 1, HSIZE, WrapEn));
                    DirLeft:  x_d = XW'(step_coord(32'(x_q), -1, HSIZE, WrapEn));
                    DirUp:    y_d = YW'(step_coord(32'(y_q), -1, VSIZE, WrapEn));
                    default:  y_d = YW'(step_coord(32'(y_q), 1, VSIZE, WrapEn));
                endcase
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = StIdle;
            end
            StClear: begin
                caddr_d = caddr_q + AW'(1);
                if (caddr_q == AW'(NPIX - 1)) begin
                    x_d     = XW'(X0);
                    y_d     = YW'(Y0);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        we    = 1'b0;
        waddr = caddr_q;
        wdata = '0;
        unique case (state_q)
            StMove: begin
                we    = i_pen_down;
                waddr = AW'(y_d) * AW'(HSIZE) + AW'(x_d);
                wdata = i_color;
            end
            StClear: we = 1'b1;
            default: ;
        endcase
        o_busy = (state_q == StMove) || (state_q == StClear);
    end

    assign o_pixel  = in_range_q ? ram_rdata : '0;
    assign o_cursor = cursor_q;
    assign o_x      = x_q;
    assign o_y      = y_q;

    trail_fb_ram #(
        .CW   (CW),
        .DEPTH(NPIX),
        .AW   (AW)
    ) u_ram (
        .clk  (CLK),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(ram_rdata)
    );

endmodule
